// File: rtl/pcie_msi_sched_if.sv
// Bundles the PCIe core MSI configuration-interrupt signals between scheduler and core.
// Latency: none, wires only.
// Backpressure: none here; the core paces the scheduler through msi_sent / msi_fail.
interface pcie_msi_sched_if;
  logic [3:0]  cfg_interrupt_msi_enable;
  logic [11:0] cfg_interrupt_msi_mmenable;
  logic [31:0] cfg_interrupt_msi_int;
  logic        cfg_interrupt_msi_sent;
  logic        cfg_interrupt_msi_fail;
  logic [3:0]  cfg_interrupt_msi_select;
  logic [31:0] cfg_interrupt_msi_pending_status;
  logic        cfg_interrupt_msi_pending_status_data_enable;
  logic [3:0]  cfg_interrupt_msi_pending_status_function_num;
  logic [2:0]  cfg_interrupt_msi_attr;
  logic        cfg_interrupt_msi_tph_present;
  logic [1:0]  cfg_interrupt_msi_tph_type;
  logic [8:0]  cfg_interrupt_msi_tph_st_tag;
  logic [3:0]  cfg_interrupt_msi_function_number;

  // Scheduler side
  modport master (
    input  cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    output cfg_interrupt_msi_int, cfg_interrupt_msi_select,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );

  // PCIe core side
  modport slave (
    output cfg_interrupt_msi_enable, cfg_interrupt_msi_mmenable,
           cfg_interrupt_msi_sent, cfg_interrupt_msi_fail,
    input  cfg_interrupt_msi_int, cfg_interrupt_msi_select,
           cfg_interrupt_msi_pending_status,
           cfg_interrupt_msi_pending_status_data_enable,
           cfg_interrupt_msi_pending_status_function_num,
           cfg_interrupt_msi_attr, cfg_interrupt_msi_tph_present,
           cfg_interrupt_msi_tph_type, cfg_interrupt_msi_tph_st_tag,
           cfg_interrupt_msi_function_number
  );
endinterface

// File: rtl/pcie_msi_sched.sv
// Latches interrupt requests and issues them one at a time as round-robin MSI strobes.
// Latency: irq_in at edge k -> msi_int strobe in the cycle after edge k+1.
// Backpressure: one MSI outstanding; waits for sent/fail (or timeout), backs off after a fail.
module pcie_msi_sched #(
  parameter int IRQ_COUNT   = 32,
  parameter int RETRY_DELAY = 16,
  parameter int TIMEOUT     = 4096
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IRQ_COUNT-1:0] irq_in,
  pcie_msi_sched_if.master     msi,
  output logic                 busy,
  output logic                 stat_fail
);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_BACKOFF} state_e;

  state_e               state_q, state_d;
  logic [IRQ_COUNT-1:0] pend_q, pend_d;
  logic [4:0]           last_q, last_d;
  logic [15:0]          tmo_q, tmo_d;
  logic [15:0]          bo_q, bo_d;
  logic [31:0]          msi_int_q, msi_int_d;
  logic                 stat_fail_q, stat_fail_d;

  logic                 grant_vld;
  logic [4:0]           grant_idx;
  logic [2:0]           mm_eff;
  logic [4:0]           vec;
  logic                 unused_cfg;

  // Round-robin search upward from the entry after the last grant, wrapping.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= IRQ_COUNT; k++) begin
      if (!grant_vld && pend_q[(int'(last_q) + k) % IRQ_COUNT]) begin
        grant_vld = 1'b1;
        grant_idx = 5'((int'(last_q) + k) % IRQ_COUNT);
      end
    end
  end

  // Vector folding: the host may grant fewer messages than sources; at most 32 are usable.
  always_comb begin
    mm_eff = (msi.cfg_interrupt_msi_mmenable[2:0] > 3'd5) ? 3'd5 : msi.cfg_interrupt_msi_mmenable[2:0];
    vec    = grant_idx & 5'((6'd1 << mm_eff) - 6'd1);
  end

  // Next-state, pending-set maintenance and strobe generation.
  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    last_d      = last_q;
    tmo_d       = tmo_q;
    bo_d        = bo_q;
    msi_int_d   = '0;
    stat_fail_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (msi.cfg_interrupt_msi_enable[0] && grant_vld) begin
          msi_int_d = 32'd1 << vec;
          for (int i = 0; i < IRQ_COUNT; i++) begin
            if (grant_idx == 5'(i)) pend_d[i] = 1'b0;
          end
          last_d  = grant_idx;
          tmo_d   = 16'(TIMEOUT);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (msi.cfg_interrupt_msi_sent) begin
          tmo_d   = '0;
          state_d = ST_IDLE;
        end else if (msi.cfg_interrupt_msi_fail || tmo_q <= 16'd1) begin
          // A lost MSI goes back into the pending set so it is retried later.
          for (int i = 0; i < IRQ_COUNT; i++) begin
            if (last_q == 5'(i)) pend_d[i] = 1'b1;
          end
          stat_fail_d = 1'b1;
          tmo_d       = '0;
          bo_d        = 16'(RETRY_DELAY);
          state_d     = ST_BACKOFF;
        end else begin
          tmo_d = tmo_q - 16'd1;
        end
      end
      ST_BACKOFF: begin
        if (bo_q <= 16'd1) begin
          bo_d    = '0;
          state_d = ST_IDLE;
        end else begin
          bo_d = bo_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // New requests are merged last so a set on the dispatch edge survives the clear.
    pend_d = pend_d | irq_in;
  end

  // State registers with synchronous reset; requests are dropped while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      pend_q      <= '0;
      last_q      <= 5'(IRQ_COUNT - 1);
      tmo_q       <= '0;
      bo_q        <= '0;
      msi_int_q   <= '0;
      stat_fail_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      last_q      <= last_d;
      tmo_q       <= tmo_d;
      bo_q        <= bo_d;
      msi_int_q   <= msi_int_d;
      stat_fail_q <= stat_fail_d;
    end
  end

  assign busy      = (state_q != ST_IDLE);
  assign stat_fail = stat_fail_q;

  assign msi.cfg_interrupt_msi_int                        = msi_int_q;
  assign msi.cfg_interrupt_msi_select                     = '0;
  assign msi.cfg_interrupt_msi_pending_status             = '0;
  assign msi.cfg_interrupt_msi_pending_status_data_enable = 1'b0;
  assign msi.cfg_interrupt_msi_pending_status_function_num = '0;
  assign msi.cfg_interrupt_msi_attr                       = '0;
  assign msi.cfg_interrupt_msi_tph_present                = 1'b0;
  assign msi.cfg_interrupt_msi_tph_type                   = '0;
  assign msi.cfg_interrupt_msi_tph_st_tag                 = '0;
  assign msi.cfg_interrupt_msi_function_number            = '0;

  // Only function 0 is served; the other functions' fields are deliberately ignored.
  assign unused_cfg = ^{msi.cfg_interrupt_msi_enable[3:1], msi.cfg_interrupt_msi_mmenable[11:3]};

endmodule

// File: tb/tb_pcie_msi_sched.sv
module tb_pcie_msi_sched;
  localparam int N  = 32;
  localparam int RD = 16;
  localparam int TO = 64;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq_in;
  logic         busy;
  logic         stat_fail;

  pcie_msi_sched_if msi_if ();

  pcie_msi_sched #(.IRQ_COUNT(N), .RETRY_DELAY(RD), .TIMEOUT(TO)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_in    (irq_in),
    .msi       (msi_if),
    .busy      (busy),
    .stat_fail (stat_fail)
  );

  always #2 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model state for the randomized phase
  logic [N-1:0] m_pend;
  logic [N-1:0] irq_prev;
  int           m_last;
  bit           outstanding;
  bit           fail_prev;
  int           delay;
  int           ndisp;
  logic [2:0]   mm_cur;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_mm(input logic [2:0] m);
    mm_cur = m;
    msi_if.cfg_interrupt_msi_mmenable = {9'd0, m};
  endtask

  task automatic pulse_irq(input logic [N-1:0] m);
    irq_in = m;
    step();
    irq_in = '0;
  endtask

  task automatic respond(input bit s, input bit f);
    msi_if.cfg_interrupt_msi_sent = s;
    msi_if.cfg_interrupt_msi_fail = f;
    step();
    msi_if.cfg_interrupt_msi_sent = 1'b0;
    msi_if.cfg_interrupt_msi_fail = 1'b0;
  endtask

  task automatic wait_msi(output int cyc, output logic [31:0] v);
    cyc = 0;
    v   = '0;
    while (v == 0 && cyc < 300) begin
      step();
      cyc++;
      v = msi_if.cfg_interrupt_msi_int;
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    repeat (2) step();
    rst = 1'b0;
  endtask

  // One cycle of the randomized run: observe, update the model, then drive.
  task automatic rnd_cycle(input bit gen);
    logic [31:0] v;
    int          g;
    bit          found;
    int          lim;
    step();
    v = msi_if.cfg_interrupt_msi_int;
    check("rnd_stat_fail", 32'(stat_fail), 32'(fail_prev));
    if (v != 0) begin
      found = 1'b0;
      g     = 0;
      for (int k = 1; k <= N; k++) begin
        if (!found && m_pend[(m_last + k) % N]) begin
          found = 1'b1;
          g     = (m_last + k) % N;
        end
      end
      lim = (mm_cur > 3'd5) ? 5 : int'(mm_cur);
      check("rnd_vec", v, found ? (32'd1 << (g % (1 << lim))) : 32'd0);
      check("rnd_single", 32'(outstanding), 32'd0);
      if (found) m_pend[g] = 1'b0;
      m_last      = g;
      outstanding = 1'b1;
      delay       = int'($urandom_range(0, 5));
      ndisp++;
    end
    m_pend = m_pend | irq_prev;
    if (fail_prev) m_pend[m_last] = 1'b1;

    msi_if.cfg_interrupt_msi_sent = 1'b0;
    msi_if.cfg_interrupt_msi_fail = 1'b0;
    fail_prev = 1'b0;
    if (outstanding) begin
      if (delay == 0) begin
        if (gen && $urandom_range(0, 7) == 0) begin
          msi_if.cfg_interrupt_msi_fail = 1'b1;
          fail_prev = 1'b1;
        end else begin
          msi_if.cfg_interrupt_msi_sent = 1'b1;
        end
        outstanding = 1'b0;
        set_mm(3'($urandom_range(0, 7)));
      end else begin
        delay--;
      end
    end
    irq_in = '0;
    if (gen) begin
      case ($urandom_range(0, 5))
        0: irq_in = N'(1) << $urandom_range(0, N - 1);
        1: irq_in = N'($urandom) & N'($urandom) & N'($urandom);
        default: irq_in = '0;
      endcase
    end
    irq_prev = irq_in;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  initial begin
    int          cyc;
    int          n;
    logic [31:0] v;
    logic [31:0] acc;
    logic [31:0] acc_b;

    rst    = 1'b1;
    irq_in = '0;
    msi_if.cfg_interrupt_msi_enable = 4'd0;
    msi_if.cfg_interrupt_msi_sent   = 1'b0;
    msi_if.cfg_interrupt_msi_fail   = 1'b0;
    set_mm(3'd0);
    repeat (3) step();

    // Reset state and constant outputs
    check("rst_msi_int", msi_if.cfg_interrupt_msi_int, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_stat_fail", 32'(stat_fail), 32'd0);
    check("const_pend_status", msi_if.cfg_interrupt_msi_pending_status, 32'd0);
    check("const_misc", 32'({msi_if.cfg_interrupt_msi_select,
                             msi_if.cfg_interrupt_msi_pending_status_data_enable,
                             msi_if.cfg_interrupt_msi_pending_status_function_num,
                             msi_if.cfg_interrupt_msi_attr,
                             msi_if.cfg_interrupt_msi_tph_present,
                             msi_if.cfg_interrupt_msi_tph_type,
                             msi_if.cfg_interrupt_msi_tph_st_tag,
                             msi_if.cfg_interrupt_msi_function_number}), 32'd0);
    rst = 1'b0;
    msi_if.cfg_interrupt_msi_enable = 4'd1;
    set_mm(3'd5);
    step();

    // Single request, latency and one-cycle strobe
    pulse_irq(N'(32'h8));
    check("lat_edge_k", msi_if.cfg_interrupt_msi_int, 32'd0);
    step();
    check("lat_edge_k1", msi_if.cfg_interrupt_msi_int, 32'h0000_0008);
    check("wait_busy", 32'(busy), 32'd1);
    step();
    check("strobe_one_cycle", msi_if.cfg_interrupt_msi_int, 32'd0);
    respond(1'b1, 1'b0);
    check("sent_busy", 32'(busy), 32'd0);
    check("sent_no_dispatch", msi_if.cfg_interrupt_msi_int, 32'd0);

    // Two simultaneous requests, round-robin order
    pulse_irq(N'(32'h5));
    wait_msi(cyc, v);
    check("rr_first", v, 32'h0000_0001);
    respond(1'b1, 1'b0);
    check("rr_no_dispatch_on_sent", msi_if.cfg_interrupt_msi_int, 32'd0);
    wait_msi(cyc, v);
    check("rr_second", v, 32'h0000_0004);
    respond(1'b1, 1'b0);
    acc = '0;
    repeat (10) begin step(); acc = acc | msi_if.cfg_interrupt_msi_int; end
    check("rr_drained", acc, 32'd0);

    // Multiple-message folding, and sent wins over fail
    set_mm(3'd2);
    pulse_irq(N'(32'h2000));
    wait_msi(cyc, v);
    check("mm2_vector", v, 32'h0000_0002);
    respond(1'b1, 1'b1);
    check("sent_prio_stat_fail", 32'(stat_fail), 32'd0);
    check("sent_prio_busy", 32'(busy), 32'd0);

    // Fail then retry after backoff
    set_mm(3'd5);
    pulse_irq(N'(32'h40));
    wait_msi(cyc, v);
    check("fail_first", v, 32'h0000_0040);
    respond(1'b0, 1'b1);
    check("fail_stat_pulse", 32'(stat_fail), 32'd1);
    step();
    check("fail_stat_one_cycle", 32'(stat_fail), 32'd0);
    wait_msi(cyc, v);
    check("retry_vector", v, 32'h0000_0040);
    check("retry_gap", 32'((cyc + 1) >= RD && (cyc + 1) <= RD + 2), 32'd1);
    respond(1'b1, 1'b0);
    check("retry_done_busy", 32'(busy), 32'd0);

    // Timeout counts as a fail, then reset mid-WAIT discards everything
    pulse_irq(N'(32'h200));
    wait_msi(cyc, v);
    check("tmo_first", v, 32'h0000_0200);
    n = 0;
    while (n < 200 && stat_fail !== 1'b1) begin step(); n++; end
    check("tmo_gap", 32'(n >= TO - 1 && n <= TO + 1), 32'd1);
    wait_msi(cyc, v);
    check("tmo_retry", v, 32'h0000_0200);
    pulse_irq(N'(32'h400));
    rst    = 1'b1;
    irq_in = N'(32'hFFFF_FFFF);
    repeat (2) step();
    rst    = 1'b0;
    irq_in = '0;
    respond(1'b1, 1'b1);
    acc   = '0;
    acc_b = '0;
    repeat (20) begin
      step();
      acc   = acc | msi_if.cfg_interrupt_msi_int;
      acc_b = acc_b | 32'({busy, stat_fail});
    end
    check("rst_wait_no_msi", acc, 32'd0);
    check("rst_wait_idle", acc_b, 32'd0);

    // Disabled: request is held, dispatched once enabled
    msi_if.cfg_interrupt_msi_enable = 4'd0;
    pulse_irq(N'(32'h80));
    acc   = '0;
    acc_b = '0;
    repeat (10) begin
      step();
      acc   = acc | msi_if.cfg_interrupt_msi_int;
      acc_b = acc_b | 32'(busy);
    end
    check("dis_no_msi", acc, 32'd0);
    check("dis_no_busy", acc_b, 32'd0);
    msi_if.cfg_interrupt_msi_enable = 4'd1;
    wait_msi(cyc, v);
    check("en_vector", v, 32'h0000_0080);
    respond(1'b1, 1'b0);

    // Randomized traffic against the reference model
    do_reset();
    m_pend      = '0;
    irq_prev    = '0;
    m_last      = N - 1;
    outstanding = 1'b0;
    fail_prev   = 1'b0;
    delay       = 0;
    ndisp       = 0;
    set_mm(3'd5);
    repeat (3000) rnd_cycle(1'b1);
    repeat (800) rnd_cycle(1'b0);
    check("rnd_model_drained", m_pend, 32'd0);
    check("rnd_busy_end", 32'(busy), 32'd0);
    check("rnd_dispatches", 32'(ndisp > 50), 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pcie_msi_sched.md
PCIE_MSI_SCHED -- requirements
Module: pcie_msi_sched

Interface
REQ-001 SHALL have parameter IRQ_COUNT, default 32; number of interrupt request inputs (1..32).
REQ-002 SHALL have parameter RETRY_DELAY, default 16; backoff cycles after a failed MSI (1..65535).
REQ-003 SHALL have parameter TIMEOUT, default 4096; cycles to wait for sent/fail before forcing fail (2..65535).
REQ-004 SHALL have port clk  in  1  PCIe user clock, 250 MHz; sole clock.
REQ-005 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-006 SHALL have port irq_in  in  IRQ_COUNT  interrupt requests; each high cycle sets that pending bit.
REQ-007 SHALL have port cfg_interrupt_msi_enable  in  4  MSI enable per function; only bit 0 is used.
REQ-008 SHALL have port cfg_interrupt_msi_mmenable  in  12  multiple-message enable; only bits [2:0] (function 0) are used.
REQ-009 SHALL have port cfg_interrupt_msi_int  out  32  one-hot MSI vector strobe to the PCIe core.
REQ-010 SHALL have port cfg_interrupt_msi_sent  in  1  core acknowledge, MSI sent.
REQ-011 SHALL have port cfg_interrupt_msi_fail  in  1  core indication, MSI failed.
REQ-012 SHALL have ports cfg_interrupt_msi_select (4), _pending_status (32), _pending_status_data_enable (1), _pending_status_function_num (4), _attr (3), _tph_present (1), _tph_type (2), _tph_st_tag (9), _function_number (4); all outputs, constant zero.
REQ-013 SHALL have port busy  out  1  high in any state other than IDLE.
REQ-014 SHALL have port stat_fail  out  1  one-cycle pulse per failed or timed-out MSI.

Function
REQ-015 SHALL keep a pending register pend[IRQ_COUNT-1:0], registered.
REQ-016 SHALL set pend[i] at any clock edge where irq_in[i]=1.
REQ-017 SHALL clear pend[g] on dispatch of grant g; a set on the same edge SHALL win, leaving pend[g]=1.
REQ-018 SHALL implement states IDLE, WAIT, BACKOFF.
REQ-019 IDLE: when msi_enable[0]=1 and pend!=0, SHALL select grant g by round-robin, searching upward from (last_grant+1) mod IRQ_COUNT with wraparound; last_grant resets to IRQ_COUNT-1, so index 0 has first priority.
REQ-020 IDLE dispatch SHALL drive cfg_interrupt_msi_int = 1<<v, registered, for exactly one cycle; clear pend[g]; record g; load the timeout counter with TIMEOUT; move to WAIT.
REQ-021 Vector v SHALL equal g AND (2^m - 1), where m = min(mmenable[2:0], 5).
REQ-022 Latency: irq_in[i] high at edge k into an idle block SHALL give msi_int high during the cycle following edge k+1.
REQ-023 WAIT: sent=1 SHALL return to IDLE at the next edge; another dispatch SHALL NOT occur in that same cycle.
REQ-024 WAIT: fail=1 SHALL set pend[g] again, pulse stat_fail, load the backoff counter with RETRY_DELAY, and move to BACKOFF.
REQ-025 WAIT: if sent and fail are high together, sent SHALL take priority.
REQ-026 WAIT: the timeout counter SHALL decrement each cycle; reaching 0 with no sent/fail SHALL be handled exactly as a fail.
REQ-027 BACKOFF: the counter SHALL decrement each cycle; at 0 the block SHALL enter IDLE. sent/fail SHALL be ignored outside WAIT.
REQ-028 With msi_enable[0]=0, SHALL remain in or return to IDLE without dispatch; pend SHALL be retained; an in-flight WAIT SHALL still complete normally.
REQ-029 Sequence: at most one MSI SHALL be outstanding; cfg_interrupt_msi_int SHALL be zero in every cycle except dispatch cycles.

Reset
REQ-030 rst SHALL clear pend, reset last_grant to IRQ_COUNT-1, enter IDLE, zero both counters, and drive msi_int=0, busy=0, stat_fail=0.
REQ-031 rst asserted mid-WAIT or mid-BACKOFF SHALL abort the transaction and discard the grant; sent/fail arriving after reset SHALL be ignored.
REQ-032 irq_in SHALL be ignored while rst=1.

Verification
REQ-033 enable=1, mm=5, irq_in[3] pulse -> msi_int=0x00000008 for one cycle two cycles later; sent -> IDLE, busy=0.
REQ-034 irq_in=0x00000005 together, sent each time -> dispatch order vector 0 then vector 2, pend=0 at end.
REQ-035 mm=2, irq_in[13] -> msi_int=0x00000002 (13 AND 3 = 1).
REQ-036 fail on first attempt, RETRY_DELAY=16 -> stat_fail pulse, re-dispatch of same vector 16-18 cycles later; sent -> done.
REQ-037 no sent/fail for TIMEOUT=64 -> stat_fail at 64 cycles, then retry; rst in WAIT -> msi_int stays 0, pend=0.
REQ-038 enable=0 with irq_in[7] -> no dispatch; raise enable -> msi_int=0x00000080.
